inst_fetch_ctrl: RTL and testbench

//   Sequences the dual-issue instruction fetch. Owns the PC, drives the instruction ROM
//   (ce/addr, combinational read of inst1 @addr and inst2 @addr+4), and buffers each fetched

---
 rtl/inst_fetch_ctrl_pkg.sv | 21 ++
 rtl/inst_fetch_ctrl_fetch_queue.sv | 93 +++++++++
 rtl/inst_fetch_ctrl.sv | 118 +++++++++++
 tb/tb_inst_fetch_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and defaults for the dual-issue instruction fetch controller.
// Holds the FSM state encoding, reset PC and fetch-queue geometry.
package inst_fetch_ctrl_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
   localparam int          QDEPTH_DEF   = 8;
   localparam int          QPTR_W_DEF   = 3;

   typedef enum logic [1:0] {
      FC_RST_WAIT = 2'd0,
      FC_FETCH    = 2'd1,
      FC_FULL     = 2'd2,
      FC_REDIRECT = 2'd3
   } fc_state_e;

   // Decode never consumes more than two entries; an encoding of 3 is clamped to 2.
   function automatic logic [1:0] sat_pop(input logic [1:0] pop_num);
      return (pop_num == 2'd3) ? 2'd2 : pop_num;
   endfunction

endpackage

// File: rtl/inst_fetch_ctrl_fetch_queue.sv
// Circular fetch queue: pushes instruction pairs, pops 0/1/2 entries per cycle.
// clr empties the queue and overrides any push or pop in the same cycle.
module fetch_queue
   import inst_fetch_ctrl_pkg::*;
#(
   parameter int QDEPTH = QDEPTH_DEF,
   parameter int QPTR_W = QPTR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              push,
   input  logic [31:0]       push_inst1,
   input  logic [31:0]       push_pc1,
   input  logic [31:0]       push_inst2,
   input  logic [31:0]       push_pc2,
   input  logic [1:0]        pop_num,
   output logic              valid1,
   output logic [31:0]       inst1,
   output logic [31:0]       pc1,
   output logic              valid2,
   output logic [31:0]       inst2,
   output logic [31:0]       pc2,
   output logic [QPTR_W:0]   count,
   output logic [QPTR_W:0]   count_nxt
);

   localparam logic [QPTR_W-1:0] PTR_ONE = QPTR_W'(1);
   localparam logic [QPTR_W-1:0] PTR_TWO = QPTR_W'(2);
   localparam logic [QPTR_W:0]   CNT_TWO = (QPTR_W+1)'(2);

   logic [31:0]       inst_mem [QDEPTH];
   logic [31:0]       pc_mem   [QDEPTH];
   logic [QPTR_W-1:0] head_q;
   logic [QPTR_W-1:0] tail_q;
   logic [QPTR_W-1:0] head_p1;
   logic [QPTR_W-1:0] tail_p1;
   logic [QPTR_W:0]   count_q;
   logic [QPTR_W:0]   pop_req;
   logic [QPTR_W:0]   eff_pop;

   assign head_p1 = head_q + PTR_ONE;
   assign tail_p1 = tail_q + PTR_ONE;

   always_comb begin
      pop_req   = {{(QPTR_W-1){1'b0}}, sat_pop(pop_num)};
      eff_pop   = (pop_req > count_q) ? count_q : pop_req;
      count_nxt = count_q + (push ? CNT_TWO : '0) - eff_pop;
      if (clr) begin
         count_nxt = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (clr) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_q + eff_pop[QPTR_W-1:0];
         if (push) begin
            tail_q <= tail_q + PTR_TWO;
         end
         count_q <= count_nxt;
      end
   end

   // Entry storage needs no reset: count_q gates every visible read.
   always_ff @(posedge clk) begin
      if (push && !clr) begin
         inst_mem[tail_q]  <= push_inst1;
         pc_mem[tail_q]    <= push_pc1;
         inst_mem[tail_p1] <= push_inst2;
         pc_mem[tail_p1]   <= push_pc2;
      end
   end

   always_comb begin
      valid1 = (count_q != '0);
      valid2 = (count_q >= CNT_TWO);
      inst1  = valid1 ? inst_mem[head_q]  : '0;
      pc1    = valid1 ? pc_mem[head_q]    : '0;
      inst2  = valid2 ? inst_mem[head_p1] : '0;
      pc2    = valid2 ? pc_mem[head_p1]   : '0;
   end

   assign count = count_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Dual-issue fetch sequencer: owns the PC, drives the instruction ROM and fills the fetch queue.
//   state       | meaning
//   RST_WAIT    | first cycle after reset release, ROM idle
//   FETCH       | ROM enabled, push a pair whenever two slots are free
//   FULL        | queue too full to accept a pair, ROM idle, PC held
//   REDIRECT    | queue was just emptied by a branch/flush, fetching from the new PC
module inst_fetch_ctrl
   import inst_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          QDEPTH   = QDEPTH_DEF,
   parameter int          QPTR_W   = QPTR_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic [31:0]     flush_pc,
   input  logic            branch_flag,
   input  logic [31:0]     branch_target,
   output logic            rom_ce,
   output logic [31:0]     rom_addr,
   input  logic [31:0]     rom_inst1,
   input  logic [31:0]     rom_inst2,
   input  logic [1:0]      pop_num,
   output logic            out_valid1,
   output logic [31:0]     out_inst1,
   output logic [31:0]     out_pc1,
   output logic            out_valid2,
   output logic [31:0]     out_inst2,
   output logic [31:0]     out_pc2,
   output logic [QPTR_W:0] q_count
);

   localparam logic [QPTR_W:0] PUSH_LIMIT = (QPTR_W+1)'(QDEPTH - 2);

   fc_state_e       state_q;
   fc_state_e       state_d;
   logic [31:0]     pc_q;
   logic [31:0]     pc_d;
   logic            redirect;
   logic            push;
   logic [QPTR_W:0] count_nxt;

   assign redirect = (state_q != FC_RST_WAIT) && (flush || branch_flag);
   assign rom_addr = pc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FC_RST_WAIT;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Room check uses the count before this cycle's pop, so a push can never overflow.
   always_comb begin
      state_d = state_q;
      rom_ce  = 1'b0;
      push    = 1'b0;
      unique case (state_q)
         FC_RST_WAIT: state_d = FC_FETCH;
         FC_FETCH, FC_REDIRECT: begin
            rom_ce = 1'b1;
            if (redirect) begin
               state_d = FC_REDIRECT;
            end else if (q_count <= PUSH_LIMIT) begin
               push    = 1'b1;
               state_d = FC_FETCH;
            end else begin
               state_d = FC_FULL;
            end
         end
         FC_FULL: begin
            if (redirect) begin
               state_d = FC_REDIRECT;
            end else if (count_nxt <= PUSH_LIMIT) begin
               state_d = FC_FETCH;
            end
         end
         default: state_d = FC_RST_WAIT;
      endcase
   end

   always_comb begin
      pc_d = pc_q;
      if (redirect) begin
         pc_d = flush ? flush_pc : branch_target;
      end else if (push) begin
         pc_d = pc_q + 32'd8;
      end
   end

   fetch_queue #(
      .QDEPTH (QDEPTH),
      .QPTR_W (QPTR_W)
   ) u_fetch_queue (
      .clk        (clk),
      .rst        (rst),
      .clr        (redirect),
      .push       (push),
      .push_inst1 (rom_inst1),
      .push_pc1   (pc_q),
      .push_inst2 (rom_inst2),
      .push_pc2   (pc_q + 32'd4),
      .pop_num    (pop_num),
      .valid1     (out_valid1),
      .inst1      (out_inst1),
      .pc1        (out_pc1),
      .valid2     (out_valid2),
      .inst2      (out_inst2),
      .pc2        (out_pc2),
      .count      (q_count),
      .count_nxt  (count_nxt)
   );

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: the driver loads expected PC streams, the monitor
// compares queue head entries and retires those decode pops.
module tb_inst_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [31:0] flush_pc;
   logic        branch_flag;
   logic [31:0] branch_target;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic [31:0] rom_inst1;
   logic [31:0] rom_inst2;
   logic [1:0]  pop_num;
   logic        out_valid1;
   logic [31:0] out_inst1;
   logic [31:0] out_pc1;
   logic        out_valid2;
   logic [31:0] out_inst2;
   logic [31:0] out_pc2;
   logic [3:0]  q_count;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_consumed = 0;
   logic [31:0] exp_q[$];

   inst_fetch_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .flush_pc      (flush_pc),
      .branch_flag   (branch_flag),
      .branch_target (branch_target),
      .rom_ce        (rom_ce),
      .rom_addr      (rom_addr),
      .rom_inst1     (rom_inst1),
      .rom_inst2     (rom_inst2),
      .pop_num       (pop_num),
      .out_valid1    (out_valid1),
      .out_inst1     (out_inst1),
      .out_pc1       (out_pc1),
      .out_valid2    (out_valid2),
      .out_inst2     (out_inst2),
      .out_pc2       (out_pc2),
      .q_count       (q_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return a ^ 32'hA5A5_5A5A;
   endfunction

   assign rom_inst1 = rom_word(rom_addr);
   assign rom_inst2 = rom_word(rom_addr + 32'd4);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic load_stream(input logic [31:0] base);
      exp_q.delete();
      for (int i = 0; i < 128; i++) exp_q.push_back(base + 32'(4 * i));
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   // Monitor: compare visible entries against the stream head, then retire what decode pops.
   always @(negedge clk) begin
      int n;
      if (rst !== 1'b1 && !flush && !branch_flag) begin
         if (out_valid1) begin
            if (exp_q.size() < 1) begin
               n_checks++; n_errors++;
               $display("FAIL sb_underflow1: got entry %h expected none", out_pc1);
            end else begin
               chk("head_pc1", out_pc1, exp_q[0]);
               chk("head_inst1", out_inst1, rom_word(exp_q[0]));
            end
         end
         if (out_valid2) begin
            if (exp_q.size() < 2) begin
               n_checks++; n_errors++;
               $display("FAIL sb_underflow2: got entry %h expected none", out_pc2);
            end else begin
               chk("head_pc2", out_pc2, exp_q[1]);
               chk("head_inst2", out_inst2, rom_word(exp_q[1]));
            end
         end
         n = (pop_num == 2'd3) ? 2 : int'(pop_num);
         if (!out_valid2 && n > 1) n = 1;
         if (!out_valid1) n = 0;
         for (int i = 0; i < n; i++) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            n_consumed++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  t2_cnt  [7];
      logic        t2_ce   [7];
      logic [31:0] t2_addr [7];
      t2_cnt  = '{4'd4, 4'd6, 4'd8, 4'd8, 4'd8, 4'd6, 4'd6};
      t2_ce   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      t2_addr = '{32'hBFC0_0028, 32'hBFC0_0030, 32'hBFC0_0038, 32'hBFC0_0038,
                  32'hBFC0_0038, 32'hBFC0_0038, 32'hBFC0_0040};

      rst = 1'b1; flush = 1'b0; flush_pc = '0; branch_flag = 1'b0;
      branch_target = '0; pop_num = 2'd2;
      load_stream(32'hBFC0_0000);
      #12;
      chk("rst_rom_ce", 32'(rom_ce), 32'd0);
      chk("rst_rom_addr", rom_addr, 32'hBFC0_0000);
      chk("rst_valid1", 32'(out_valid1), 32'd0);
      chk("rst_valid2", 32'(out_valid2), 32'd0);
      chk("rst_pc1", out_pc1, 32'd0);
      chk("rst_inst1", out_inst1, 32'd0);
      chk("rst_count", 32'(q_count), 32'd0);

      // Test 1: release reset with decode popping two per cycle.
      cyc(); rst = 1'b0;
      at_neg();
      chk("t1_wait_ce", 32'(rom_ce), 32'd0);
      for (int i = 1; i <= 5; i++) begin
         cyc();
         if (i == 5) pop_num = 2'd0;
         at_neg();
         chk("t1_ce", 32'(rom_ce), 32'd1);
         chk("t1_addr", rom_addr, 32'hBFC0_0000 + 32'(8 * (i - 1)));
         if (i == 2) begin
            chk("t1_pc1", out_pc1, 32'hBFC0_0000);
            chk("t1_pc2", out_pc2, 32'hBFC0_0004);
         end
      end

      // Test 2: stall decode until the queue fills, then drain by two.
      for (int j = 0; j < 7; j++) begin
         cyc();
         if (j == 0) chk("t1_consumed", 32'(n_consumed), 32'd6);
         if (j == 4) pop_num = 2'd2;
         at_neg();
         chk("t2_count", 32'(q_count), 32'(t2_cnt[j]));
         chk("t2_ce", 32'(rom_ce), 32'(t2_ce[j]));
         chk("t2_addr", rom_addr, t2_addr[j]);
      end

      // Test 3: single pops, head walks across the pointer wrap.
      for (int j = 0; j < 20; j++) begin
         cyc();
         if (j == 0) pop_num = 2'd1;
         at_neg();
      end

      // Test 5: flush and branch together; flush target wins.
      cyc();
      flush = 1'b1; flush_pc = 32'hBFC0_0380;
      branch_flag = 1'b1; branch_target = 32'hBFC0_0100; pop_num = 2'd2;
      load_stream(32'hBFC0_0380);
      cyc();
      flush = 1'b0; branch_flag = 1'b0; pop_num = 2'd0;
      at_neg();
      chk("t5_count", 32'(q_count), 32'd0);
      chk("t5_valid1", 32'(out_valid1), 32'd0);
      chk("t5_addr", rom_addr, 32'hBFC0_0380);
      chk("t5_ce", 32'(rom_ce), 32'd1);
      cyc();
      at_neg();
      chk("t5_count2", 32'(q_count), 32'd2);
      chk("t5_pc1", out_pc1, 32'hBFC0_0380);
      chk("t5_addr2", rom_addr, 32'hBFC0_0388);
      cyc();
      pop_num = 2'd1;
      at_neg();

      // Test 4: branch with five entries queued.
      cyc();
      chk("t4_count5", 32'(q_count), 32'd5);
      branch_flag = 1'b1; branch_target = 32'hBFC0_0100; pop_num = 2'd0;
      load_stream(32'hBFC0_0100);
      cyc();
      branch_flag = 1'b0;
      at_neg();
      chk("t4_count", 32'(q_count), 32'd0);
      chk("t4_valid1", 32'(out_valid1), 32'd0);
      chk("t4_addr", rom_addr, 32'hBFC0_0100);
      cyc();
      at_neg();
      chk("t4_pc1", out_pc1, 32'hBFC0_0100);
      chk("t4_count2", 32'(q_count), 32'd2);

      // Test 6: asynchronous reset mid-stream, then restart.
      for (int j = 0; j < 3; j++) begin
         cyc();
         pop_num = 2'd2;
         at_neg();
      end
      cyc();
      rst = 1'b1;
      #1;
      chk("t6_valid1", 32'(out_valid1), 32'd0);
      chk("t6_pc1", out_pc1, 32'd0);
      chk("t6_count", 32'(q_count), 32'd0);
      chk("t6_ce", 32'(rom_ce), 32'd0);
      chk("t6_addr", rom_addr, 32'hBFC0_0000);
      load_stream(32'hBFC0_0000);
      cyc();
      rst = 1'b0;
      at_neg();
      chk("t6_wait_ce", 32'(rom_ce), 32'd0);
      cyc();
      at_neg();
      chk("t6_fetch_ce", 32'(rom_ce), 32'd1);
      chk("t6_fetch_addr", rom_addr, 32'hBFC0_0000);
      cyc();
      at_neg();
      chk("t6_pc1", out_pc1, 32'hBFC0_0000);
      chk("t6_pc2", out_pc2, 32'hBFC0_0004);
      for (int j = 0; j < 3; j++) begin
         cyc();
         at_neg();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
